// File: rtl/cache_flush_controller.sv
// ---------------------------------------------------------------------------
// cache_flush_controller
//
// Purpose:
//   Merges one-cycle flush requests from NUM_REQUESTERS clients into shared
//   flush passes over a write-back cache tag/state array. A pass visits every
//   (set, way) in order: set-major, way-minor. For each line it reads the tag
//   state, hands dirty lines to the write-back unit through a valid/ready
//   handshake, and then rewrites the line state so that it is clean.
//   Requests that arrive while a pass is running (including in its final
//   cycle) are held pending and are served by a fresh pass. Any line dirtied
//   during a pass is therefore still flushed before that requester completes.
//
// Build option:
//   RSD_CACHE_FLUSH_INVALIDATE_EN
//     defined   : invalidating flush. Every valid line is rewritten with
//                 valid=0, dirty=0.
//     undefined : clean-only flush. Only dirty lines are rewritten, with
//                 valid=1, dirty=0.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   flushReq       per-client one-cycle request pulse
//   flushComplete  per-client one-cycle completion pulse
//   busy           a pass is in progress
//   tagRdEn        tag/state read strobe; data returns the next cycle
//   tagRdIndex     set to read
//   tagRdWay       way to read
//   tagRdValid     returned valid bit
//   tagRdDirty     returned dirty bit
//   wbValid        write-back request for a dirty line
//   wbIndex        set of the line being written back
//   wbWay          way of the line being written back
//   wbReady        write-back path accepts the request
//   lineWe         tag/state write strobe
//   lineIndex      set to write
//   lineWay        way to write
//   lineValidNext  valid bit to write
//   lineDirtyNext  dirty bit to write (always 0)
// ---------------------------------------------------------------------------
module cache_flush_controller #(
  parameter  int NUM_REQUESTERS = 2,
  parameter  int NUM_SETS       = 64,
  parameter  int NUM_WAYS       = 2,
  localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
  localparam int WAY_WIDTH      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQUESTERS-1:0] flushReq,
  output logic [NUM_REQUESTERS-1:0] flushComplete,
  output logic                      busy,
  output logic                      tagRdEn,
  output logic [INDEX_WIDTH-1:0]    tagRdIndex,
  output logic [WAY_WIDTH-1:0]      tagRdWay,
  input  logic                      tagRdValid,
  input  logic                      tagRdDirty,
  output logic                      wbValid,
  output logic [INDEX_WIDTH-1:0]    wbIndex,
  output logic [WAY_WIDTH-1:0]      wbWay,
  input  logic                      wbReady,
  output logic                      lineWe,
  output logic [INDEX_WIDTH-1:0]    lineIndex,
  output logic [WAY_WIDTH-1:0]      lineWay,
  output logic                      lineValidNext,
  output logic                      lineDirtyNext
);

`ifdef RSD_CACHE_FLUSH_INVALIDATE_EN
  // Invalidating flush: every valid line is rewritten as invalid.
  localparam logic WRITE_CLEAN_LINES = 1'b1;
  localparam logic WRITE_VALID_BIT   = 1'b0;
`else
  // Clean-only flush: dirty lines stay resident but become clean.
  localparam logic WRITE_CLEAN_LINES = 1'b0;
  localparam logic WRITE_VALID_BIT   = 1'b1;
`endif

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_SETS - 1);
  localparam logic [WAY_WIDTH-1:0]   LAST_WAY   = WAY_WIDTH'(NUM_WAYS - 1);
  localparam logic [INDEX_WIDTH-1:0] INDEX_ONE  = INDEX_WIDTH'(1);
  localparam logic [WAY_WIDTH-1:0]   WAY_ONE    = WAY_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WB,
    WRITE,
    DONE
  } stateT;

  stateT                      state;
  logic [NUM_REQUESTERS-1:0]  pendingReg;
  logic [NUM_REQUESTERS-1:0]  servedReg;
  logic [NUM_REQUESTERS-1:0]  flushCompleteReg;
  logic [INDEX_WIDTH-1:0]     indexReg;
  logic [WAY_WIDTH-1:0]       wayReg;
  logic                       busyReg;
  logic                       tagRdEnReg;
  logic                       wbValidReg;
  logic                       lineWeReg;
  logic                       lineValidNextReg;

  // Line cursor arithmetic shared by the CHECK and WRITE exits.
  logic                       lastWay;
  logic                       lastLine;
  logic [INDEX_WIDTH-1:0]     indexAdv;
  logic [WAY_WIDTH-1:0]       wayAdv;
  logic                       anyRequest;

  always_comb begin
    lastWay    = (wayReg == LAST_WAY);
    // Termination uses the explicit last-line compare; the counters
    // themselves simply wrap back to zero.
    lastLine   = lastWay && (indexReg == LAST_INDEX);
    wayAdv     = lastWay ? '0 : (wayReg + WAY_ONE);
    indexAdv   = lastWay ? (indexReg + INDEX_ONE) : indexReg;
    anyRequest = |(pendingReg | flushReq);
  end

  // -------------------------------------------------------------------------
  // Per-client request bookkeeping.
  //   pending : requests not yet attached to a pass
  //   served  : clients attached to the pass in progress
  // A request is attached only when the FSM leaves IDLE, so a pulse seen in
  // any other state (DONE included) waits for the next pass. A repeated
  // pulse from a client that is already pending just re-sets the same bit.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : genClient
    logic pendingBit;
    logic servedBit;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pendingBit <= 1'b0;
        servedBit  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // With no request anywhere this loads zero, which is a no-op.
            servedBit  <= pendingBit | flushReq[gi];
            pendingBit <= 1'b0;
          end
          DONE: begin
            servedBit  <= 1'b0;
            pendingBit <= pendingBit | flushReq[gi];
          end
          default: begin
            pendingBit <= pendingBit | flushReq[gi];
          end
        endcase
      end
    end

    assign pendingReg[gi] = pendingBit;
    assign servedReg[gi]  = servedBit;
  end

  // -------------------------------------------------------------------------
  // Pass sequencer. Strobe outputs are registered: each is set on the
  // transition into the state that owns it, so it is high exactly while
  // that state is current.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      indexReg         <= '0;
      wayReg           <= '0;
      busyReg          <= 1'b0;
      tagRdEnReg       <= 1'b0;
      wbValidReg       <= 1'b0;
      lineWeReg        <= 1'b0;
      lineValidNextReg <= 1'b0;
      flushCompleteReg <= '0;
    end else begin
      // Single-cycle strobes drop unless re-armed below.
      tagRdEnReg       <= 1'b0;
      lineWeReg        <= 1'b0;
      lineValidNextReg <= 1'b0;
      flushCompleteReg <= '0;

      case (state)
        IDLE: begin
          if (anyRequest) begin
            indexReg   <= '0;
            wayReg     <= '0;
            busyReg    <= 1'b1;
            tagRdEnReg <= 1'b1;
            state      <= READ;
          end
        end

        READ: begin
          // Tag data for the current line comes back during CHECK.
          state <= CHECK;
        end

        CHECK: begin
          if (tagRdValid && tagRdDirty) begin
            wbValidReg <= 1'b1;
            state      <= WB;
          end else if (WRITE_CLEAN_LINES && tagRdValid) begin
            lineWeReg        <= 1'b1;
            lineValidNextReg <= WRITE_VALID_BIT;
            state            <= WRITE;
          end else begin
            indexReg <= indexAdv;
            wayReg   <= wayAdv;
            if (lastLine) begin
              flushCompleteReg <= servedReg;
              state            <= DONE;
            end else begin
              tagRdEnReg <= 1'b1;
              state      <= READ;
            end
          end
        end

        WB: begin
          // The request and its index/way stay put until accepted; there is
          // deliberately no timeout.
          if (wbReady) begin
            wbValidReg       <= 1'b0;
            lineWeReg        <= 1'b1;
            lineValidNextReg <= WRITE_VALID_BIT;
            state            <= WRITE;
          end
        end

        WRITE: begin
          indexReg <= indexAdv;
          wayReg   <= wayAdv;
          if (lastLine) begin
            flushCompleteReg <= servedReg;
            state            <= DONE;
          end else begin
            tagRdEnReg <= 1'b1;
            state      <= READ;
          end
        end

        DONE: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          busyReg    <= 1'b0;
          wbValidReg <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // The line cursor drives all three address buses. It returns to zero at
  // the end of every pass, so the buses read zero whenever the block idles.
  assign flushComplete = flushCompleteReg;
  assign busy          = busyReg;
  assign tagRdEn       = tagRdEnReg;
  assign tagRdIndex    = indexReg;
  assign tagRdWay      = wayReg;
  assign wbValid       = wbValidReg;
  assign wbIndex       = indexReg;
  assign wbWay         = wayReg;
  assign lineWe        = lineWeReg;
  assign lineIndex     = indexReg;
  assign lineWay       = wayReg;
  assign lineValidNext = lineValidNextReg;
  assign lineDirtyNext = 1'b0;

endmodule

// File: tb/tb_cache_flush_controller.sv
`timescale 1ns/1ps
module tb_cache_flush_controller;

  localparam int NR = 2;
  localparam int NS = 4;
  localparam int NW = 2;
`ifdef RSD_CACHE_FLUSH_INVALIDATE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] flushReq = '0;
  logic [NR-1:0] flushComplete;
  logic          busy;
  logic          tagRdEn;
  logic [1:0]    tagRdIndex;
  logic [0:0]    tagRdWay;
  logic          tagRdValid = 1'b0;
  logic          tagRdDirty = 1'b0;
  logic          wbValid;
  logic [1:0]    wbIndex;
  logic [0:0]    wbWay;
  logic          wbReady = 1'b1;
  logic          lineWe;
  logic [1:0]    lineIndex;
  logic [0:0]    lineWay;
  logic          lineValidNext;
  logic          lineDirtyNext;

  cache_flush_controller #(
    .NUM_REQUESTERS(NR),
    .NUM_SETS(NS),
    .NUM_WAYS(NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flushReq(flushReq),
    .flushComplete(flushComplete),
    .busy(busy),
    .tagRdEn(tagRdEn),
    .tagRdIndex(tagRdIndex),
    .tagRdWay(tagRdWay),
    .tagRdValid(tagRdValid),
    .tagRdDirty(tagRdDirty),
    .wbValid(wbValid),
    .wbIndex(wbIndex),
    .wbWay(wbWay),
    .wbReady(wbReady),
    .lineWe(lineWe),
    .lineIndex(lineIndex),
    .lineWay(lineWay),
    .lineValidNext(lineValidNext),
    .lineDirtyNext(lineDirtyNext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;
  int nWrites = 0;

  // Tag/state array model driven back into the DUT.
  logic cacheValid [NS][NW];
  logic cacheDirty [NS][NW];

  typedef struct { logic [NR-1:0] mask; int cycle; } compT;
  typedef struct { int idx; int way; logic valid; bit fromWb; } writeT;
  typedef struct { int idx; int way; } wbT;

  compT  compQ[$];
  writeT wrQ[$];
  wbT    wbQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from the first READ to the DONE cycle, from the line model.
  function automatic int passLen(input int stall);
    int n = 0;
    for (int i = 0; i < NS; i++)
      for (int w = 0; w < NW; w++)
        if (cacheValid[i][w] && cacheDirty[i][w]) n += 4 + stall;
        else if (cacheValid[i][w] && INV)        n += 3;
        else                                      n += 2;
    return n;
  endfunction

  task automatic pushPassEvents();
    for (int i = 0; i < NS; i++)
      for (int w = 0; w < NW; w++)
        if (cacheValid[i][w] && cacheDirty[i][w]) begin
          wbQ.push_back('{idx: i, way: w});
          wrQ.push_back('{idx: i, way: w, valid: !INV, fromWb: 1'b1});
        end else if (cacheValid[i][w] && INV) begin
          wrQ.push_back('{idx: i, way: w, valid: 1'b0, fromWb: 1'b0});
        end
  endtask

  task automatic setAll(input logic v, input logic d);
    for (int i = 0; i < NS; i++)
      for (int w = 0; w < NW; w++) begin
        cacheValid[i][w] = v;
        cacheDirty[i][w] = d;
      end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [NR-1:0] m);
    flushReq = m;
    @(negedge clk);
    flushReq = '0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((compQ.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pass_done_in_budget", {31'd0, (compQ.size() == 0 && !busy)}, 32'd1);
  endtask

  // Tag responder and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    compT  c;
    writeT w;
    if (tagRdEn) begin
      tagRdValid = cacheValid[tagRdIndex][tagRdWay];
      tagRdDirty = cacheDirty[tagRdIndex][tagRdWay];
    end
    if (flushComplete != '0) begin
      if (compQ.size() == 0) check("unexpected_complete", {30'd0, flushComplete}, 32'd0);
      else begin
        c = compQ.pop_front();
        check("complete_mask", {30'd0, flushComplete}, {30'd0, c.mask});
        check("complete_cycle", cyc, c.cycle);
        $display("cycle %0d: flushComplete=%b", cyc, flushComplete);
      end
    end
    if (wbValid) begin
      if (wbQ.size() == 0) check("unexpected_wb", {31'd0, wbValid}, 32'd0);
      else begin
        check("wb_index", {30'd0, wbIndex}, wbQ[0].idx);
        check("wb_way", {31'd0, wbWay}, wbQ[0].way);
      end
    end
    if (lineWe) begin
      nWrites++;
      if (wrQ.size() == 0) check("unexpected_write", {31'd0, lineWe}, 32'd0);
      else begin
        w = wrQ.pop_front();
        check("write_index", {30'd0, lineIndex}, w.idx);
        check("write_way", {31'd0, lineWay}, w.way);
        check("write_valid", {31'd0, lineValidNext}, {31'd0, w.valid});
        check("write_dirty", {31'd0, lineDirtyNext}, 32'd0);
        if (w.fromWb && wbQ.size() > 0) wbQ.delete(0);
        $display("cycle %0d: write line (%0d,%0d) valid=%b", cyc, lineIndex, lineWay, lineValidNext);
      end
      cacheValid[lineIndex][lineWay] = lineValidNext;
      cacheDirty[lineIndex][lineWay] = lineDirtyNext;
    end
  end

  int t;
  int n;
  int wrBefore;

  initial begin
    setAll(1'b0, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tagRdEn", {31'd0, tagRdEn}, 32'd0);
    check("rst_complete", {30'd0, flushComplete}, 32'd0);
    check("rst_wb_we", {30'd0, wbValid, lineWe}, 32'd0);
    check("rst_index", {29'd0, tagRdIndex, tagRdWay}, 32'd0);
    rst = 1'b1;

    // Baseline pass over invalid lines, request at cycle 10.
    waitUntil(10);
    check("idle_busy", {31'd0, busy}, 32'd0);
    compQ.push_back('{mask: 2'b01, cycle: 27});
    pulse(2'b01);
    check("read_start_en", {31'd0, tagRdEn}, 32'd1);
    check("read_start_line", {29'd0, tagRdIndex, tagRdWay}, 32'd0);
    check("busy_first", {31'd0, busy}, 32'd1);
    waitUntil(27);
    check("busy_done_cycle", {31'd0, busy}, 32'd1);
    waitUntil(28);
    check("busy_after", {31'd0, busy}, 32'd0);

    // Simultaneous requests share one pass.
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b11, cycle: t + 17});
    pulse(2'b11);
    waitDone(100);

    // Second client arrives mid-pass, twice: one extra pass, one completion.
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b01, cycle: t + 17});
    compQ.push_back('{mask: 2'b10, cycle: t + 35});
    pulse(2'b01);
    waitUntil(t + 5);
    pulse(2'b10);
    waitUntil(t + 8);
    pulse(2'b10);
    waitDone(100);

    // Second client arrives exactly in the DONE cycle.
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b01, cycle: t + 17});
    compQ.push_back('{mask: 2'b10, cycle: t + 35});
    pulse(2'b01);
    waitUntil(t + 17);
    pulse(2'b10);
    waitDone(100);

    // Dirty line (2,1) with write-back stalled for 5 cycles.
    cacheValid[2][1] = 1'b1;
    cacheDirty[2][1] = 1'b1;
    wbReady = 1'b0;
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b01, cycle: t + 1 + passLen(5)});
    pushPassEvents();
    pulse(2'b01);
    n = 0;
    while (!wbValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wb_seen", {31'd0, wbValid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("wb_hold_valid", {31'd0, wbValid}, 32'd1);
      check("wb_hold_line", {29'd0, wbIndex, wbWay}, {29'd0, 2'd2, 1'b1});
      @(negedge clk);
    end
    check("wb_hold_last", {31'd0, wbValid}, 32'd1);
    wbReady = 1'b1;
    @(negedge clk);
    check("wb_write_after", {31'd0, lineWe}, 32'd1);
    check("wb_dropped", {31'd0, wbValid}, 32'd0);
    waitDone(100);

    // Reset mid-pass with another request pending: nothing completes.
    setAll(1'b0, 1'b0);
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b01, cycle: t + 17});
    pulse(2'b01);
    pulse(2'b10);
    waitUntil(t + 4);
    rst = 1'b0;
    compQ.delete();
    wrQ.delete();
    wbQ.delete();
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tagRdEn", {31'd0, tagRdEn}, 32'd0);
    check("midrst_complete", {30'd0, flushComplete}, 32'd0);
    check("midrst_index", {29'd0, tagRdIndex, tagRdWay}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("pending_lost", {31'd0, busy}, 32'd0);
    t = cyc;
    compQ.push_back('{mask: 2'b10, cycle: t + 17});
    pulse(2'b10);
    check("post_rst_start", {28'd0, tagRdEn, tagRdIndex, tagRdWay}, 32'h8);
    waitDone(100);

    // All lines valid and clean: writes only for an invalidating flush.
    setAll(1'b1, 1'b0);
    wrBefore = nWrites;
    t = cyc + 2;
    waitUntil(t);
    compQ.push_back('{mask: 2'b01, cycle: t + 1 + (INV ? 24 : 16)});
    pushPassEvents();
    pulse(2'b01);
    waitDone(100);
    check("clean_write_count", nWrites - wrBefore, INV ? 8 : 0);

    check("queues_drained", compQ.size() + wrQ.size() + wbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cache_flush_controller.md
Name: cache_flush_controller

Overview:
- Parametrised successor to the single-requester flush handshake.
- Accepts flush requests from NUM_REQUESTERS clients (e.g. MemoryExecutionStage per port, fence unit) and merges them into shared flush passes.
- Each pass walks every set and way of a write-back cache tag array, hands dirty lines to the write-back path through a valid/ready handshake, then invalidates or cleans each line.
- Sits between the requesting pipeline stages and the D-cache tag/state array plus the write-back/miss unit.

Parameters:
NUM_REQUESTERS, 2, number of independent flush clients
NUM_SETS, 64, cache sets (power of 2, >=2); INDEX_WIDTH = $clog2(NUM_SETS)
NUM_WAYS, 2, cache ways (power of 2, >=1); WAY_WIDTH = max(1, $clog2(NUM_WAYS))

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flushReq  in  NUM_REQUESTERS  one-cycle request pulse per client
flushComplete  out  NUM_REQUESTERS  one-cycle completion pulse per served client
busy  out  1  high while a pass is in progress (state != IDLE)
tagRdEn  out  1  tag/state array read strobe
tagRdIndex  out  INDEX_WIDTH  set to read
tagRdWay  out  WAY_WIDTH  way to read
tagRdValid  in  1  line valid bit; returned the cycle after tagRdEn
tagRdDirty  in  1  line dirty bit; returned the cycle after tagRdEn
wbValid  out  1  dirty-line write-back request
wbIndex  out  INDEX_WIDTH  set of the line being written back
wbWay  out  WAY_WIDTH  way of the line being written back
wbReady  in  1  write-back path accepts the request
lineWe  out  1  tag/state write strobe
lineIndex  out  INDEX_WIDTH  set to write
lineWay  out  WAY_WIDTH  way to write
lineValidNext  out  1  valid bit to write
lineDirtyNext  out  1  dirty bit to write (always 0)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pending=0, served=0, index=0, way=0. All outputs 0.
- pending[i] is set by flushReq[i] in any state.
- States:
  - IDLE: if (pending|flushReq)!=0, then served <= pending|flushReq, pending <= 0, index <= 0, way <= 0, go to READ. Otherwise stay in IDLE.
  - READ: tagRdEn=1, tagRdIndex=index, tagRdWay=way. Go to CHECK.
  - CHECK: samples tagRdValid and tagRdDirty.
    - valid & dirty: go to WB.
    - Line needs a write (see Optional Feature): go to WRITE.
    - Otherwise: advance.
  - WB: wbValid=1 with wbIndex/wbWay held stable until wbValid & wbReady. On that handshake cycle go to WRITE. No timeout.
  - WRITE: lineWe=1 for one cycle with lineIndex/lineWay = current line, lineDirtyNext=0. Then advance.
  - advance: way+1. When way wraps from NUM_WAYS-1 to 0, index+1.
    - If the current line was index=NUM_SETS-1, way=NUM_WAYS-1: go to DONE.
    - Otherwise: go to READ.
  - DONE: flushComplete = served for exactly one cycle, served <= 0, go to IDLE.
- Latency with no dirty/written lines: a request pulse in cycle t gives READ at t+1 and the flushComplete pulse at t+1+2*NUM_SETS*NUM_WAYS.
- Each dirty line adds 2 cycles plus the wbReady wait.
- A flushReq arriving while busy (including in the DONE cycle) is never folded into the current pass. It is kept pending and starts a new pass from IDLE. Lines dirtied mid-pass are therefore guaranteed flushed.
- A duplicate pulse from a client that is already pending is absorbed; the client gets one completion.
- Simultaneous pulses from several clients in the same IDLE cycle give one pass; all of those clients receive flushComplete in the same cycle.
- Reset asserted mid-pass aborts immediately with no completion; pending requests are lost.
- Counter index/way wrap is natural modulo 2^width. The termination test uses the explicit last-line compare.

Optional Feature:
- Macro RSD_CACHE_FLUSH_INVALIDATE_EN.
- Defined (invalidating flush):
  - Every valid line gets a WRITE with lineValidNext=0, lineDirtyNext=0.
  - Invalid lines skip WRITE.
- Undefined (clean-only flush):
  - Only dirty lines get a WRITE, with lineValidNext=1, lineDirtyNext=0.
  - Valid clean lines and invalid lines skip WRITE.

Test Plan:
- NUM_SETS=4, NUM_WAYS=2, all lines invalid. flushReq=2'b01 at cycle 10 -> READ at 11, flushComplete=2'b01 only at cycle 27, wbValid and lineWe never asserted, busy high cycles 11-27.
- Same config, line (index 2, way 1) valid+dirty, wbReady held 0 for 5 cycles -> wbValid stays high with wbIndex=2, wbWay=1 throughout. One lineWe at (2,1) the cycle after the handshake (valid 0 if macro defined, else 1). Completion delayed by 2+5 cycles over the baseline.
- flushReq=2'b11 in the same cycle -> one pass, flushComplete=2'b11 in a single cycle.
- flushReq[0] pulse at cycle 10, flushReq[1] pulse at cycle 15 -> flushComplete=2'b01 at cycle 27. IDLE at 28 starts a second pass. flushComplete=2'b10 at cycle 45.
- Reset (rst=0) at cycle 14 mid-pass -> all outputs 0, busy 0, no flushComplete. A new pulse after rst=1 runs a full pass from index 0.
- Macro comparison: all 8 lines valid and clean -> defined: 8 lineWe writes with lineValidNext=0, completion at +1+3*8. Undefined: zero writes, completion at +1+2*8.
